// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX FIFO write-side signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr, fifo_wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART TX FIFO write port
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [GW-1:0] pick;
  logic          found;
  logic          beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

  // First valid requester strictly after the last owner, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = GW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    beat_d         = beat_q;
    idle_d         = idle_q;
    beat           = 1'b0;
    bus.req_ready  = '0;
    bus.fifo_wr    = 1'b0;
    bus.fifo_wdata = '0;

    case (state_q)
      XFER: begin
        bus.req_ready[grant_q] = ~bus.fifo_full;
        bus.fifo_wdata         = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        beat                   = bus.req_valid[grant_q] & ~bus.fifo_full;
        bus.fifo_wr            = beat;
        if (beat) begin
          beat_d = beat_q + BW'(1);
          idle_d = '0;
          if (bus.req_last[grant_q] || (beat_q == BW'(MAX_BURST - 1))) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end else if (!bus.req_valid[grant_q]) begin
          // A stall on fifo_full with valid held high keeps both counters frozen.
          idle_d = idle_q + IW'(1);
          if (idle_q == IW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: begin
        if (found) begin
          state_d = XFER;
          grant_d = pick;
          beat_d  = '0;
          idle_d  = '0;
        end
      end
    endcase
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int TO = 8;
  localparam int RLEN = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] d [N];
  int cnt [N];
  int lim [N];
  int base [N];
  int last_at [N];

  logic [7:0] rb [N][RLEN];
  logic       rl [N][RLEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic full);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = full;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = d[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; lim[i] = 0; base[i] = 0; last_at[i] = -1; d[i] = 8'h00;
    end
    drive('0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Each requester offers bytes base+cnt until lim is reached.
  task automatic drive_frames(input logic full);
    logic [N-1:0] v, l;
    v = '0;
    l = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt[i] < lim[i]) begin
        v[i] = 1'b1;
        d[i] = 8'(base[i] + cnt[i]);
        l[i] = (cnt[i] == last_at[i]);
      end
    end
    drive(v, l, full);
  endtask

  task automatic advance(input logic [N-1:0] hs);
    for (int i = 0; i < N; i++) if (hs[i]) cnt[i]++;
  endtask

  task automatic expect_cycle(input string tag, input logic eb, input int eg,
                              input logic ewr, input logic [7:0] ed);
    check({tag, "_busy"}, 32'(bus.busy), 32'(eb));
    if (eb) check({tag, "_grant"}, 32'(bus.grant_id), 32'(eg));
    check({tag, "_wr"}, 32'(bus.fifo_wr), 32'(ewr));
    if (ewr) check({tag, "_data"}, 32'(bus.fifo_wdata), 32'(ed));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_wr"},    32'(bus.fifo_wr), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'd0);
    check({tag, "_grant"}, 32'(bus.grant_id), 32'd0);
  endtask

  function automatic int rr(input int p, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] hs, v, l, prev_valid, exp_ready;
    logic full, b, prev_busy, prev_cause, cause, exp_wr, all_done;
    int g, prev_owner, last_owner, beats, idles, cyc;

    rst = 1'b0;
    for (int i = 0; i < N; i++) d[i] = 8'h00;
    drive('0, '0, 1'b0);
    #2;
    check_reset_outputs("reset");
    do_reset();

    // Single 3-byte frame from requester 1.
    d[1] = 8'hA1;
    drive(4'b0010, 4'b0000, 1'b0);
    @(negedge clk);
    expect_cycle("t1_arb", 1'b0, 0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      d[1] = 8'(8'hA1 + k);
      drive(4'b0010, (k == 2) ? 4'b0010 : 4'b0000, 1'b0);
      @(negedge clk);
      expect_cycle("t1_beat", 1'b1, 1, 1'b1, 8'(8'hA1 + k));
      check("t1_ready", 32'(bus.req_ready), 32'h2);
    end
    tick();
    drive('0, '0, 1'b0);
    @(negedge clk);
    expect_cycle("t1_done", 1'b0, 0, 1'b0, 8'h00);

    // All requesters valid with 1-beat frames: rotation with a dead cycle.
    do_reset();
    for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);
    drive(4'hF, 4'hF, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      expect_cycle("t2_gap", 1'b0, 0, 1'b0, 8'h00);
      tick();
      @(negedge clk);
      expect_cycle("t2_grant", 1'b1, k % N, 1'b1, 8'(8'h10 + (k % N)));
      tick();
    end

    // Burst limit: requester 2 streams 20 bytes, requester 3 waits.
    do_reset();
    lim[2] = 20; base[2] = 8'h40;
    lim[3] = 1;  base[3] = 8'h30; last_at[3] = 0;
    for (int c = 0; c < 34; c++) begin
      drive_frames(1'b0);
      @(negedge clk);
      if (c == 0 || c == 17 || c == 19 || c >= 32) expect_cycle("t3_idle", 1'b0, 0, 1'b0, 8'h00);
      else if (c <= 16) expect_cycle("t3_burst", 1'b1, 2, 1'b1, 8'(8'h40 + c - 1));
      else if (c == 18) expect_cycle("t3_r3", 1'b1, 3, 1'b1, 8'h30);
      else if (c <= 23) expect_cycle("t3_resume", 1'b1, 2, 1'b1, 8'(8'h40 + 16 + c - 20));
      else expect_cycle("t3_tmo", 1'b1, 2, 1'b0, 8'h00);
      hs = bus.req_ready & bus.req_valid;
      tick();
      advance(hs);
    end

    // FIFO full for 10 cycles mid-burst: no write, no counter advance.
    do_reset();
    lim[0] = 17; base[0] = 8'h80; last_at[0] = 16;
    for (int c = 0; c < 30; c++) begin
      drive_frames(c >= 3 && c <= 12);
      @(negedge clk);
      if (c == 0 || c == 27 || c == 29) expect_cycle("t4_idle", 1'b0, 0, 1'b0, 8'h00);
      else if (c <= 2) expect_cycle("t4_pre", 1'b1, 0, 1'b1, 8'(8'h80 + c - 1));
      else if (c <= 12) begin
        expect_cycle("t4_stall", 1'b1, 0, 1'b0, 8'h00);
        check("t4_ready", 32'(bus.req_ready), 32'd0);
      end
      else if (c <= 26) expect_cycle("t4_post", 1'b1, 0, 1'b1, 8'(8'h80 + c - 11));
      else expect_cycle("t4_regrant", 1'b1, 0, 1'b1, 8'h90);
      hs = bus.req_ready & bus.req_valid;
      tick();
      advance(hs);
    end

    // Timeout: requester 1 goes silent after 2 beats, requester 3 is waiting.
    do_reset();
    lim[1] = 2; base[1] = 8'h50;
    lim[3] = 1; base[3] = 8'h70; last_at[3] = 0;
    for (int c = 0; c < 14; c++) begin
      drive_frames(1'b0);
      @(negedge clk);
      if (c == 0 || c == 11 || c == 13) expect_cycle("t5_idle", 1'b0, 0, 1'b0, 8'h00);
      else if (c <= 2) expect_cycle("t5_beat", 1'b1, 1, 1'b1, 8'(8'h50 + c - 1));
      else if (c <= 10) expect_cycle("t5_wait", 1'b1, 1, 1'b0, 8'h00);
      else expect_cycle("t5_next", 1'b1, 3, 1'b1, 8'h70);
      hs = bus.req_ready & bus.req_valid;
      tick();
      advance(hs);
    end

    // Asynchronous reset during beat 5, then requester 0 wins first.
    do_reset();
    lim[2] = 8; base[2] = 8'h60; last_at[2] = 7;
    for (int c = 0; c < 6; c++) begin
      drive_frames(1'b0);
      @(negedge clk);
      if (c == 0) expect_cycle("t6_idle", 1'b0, 0, 1'b0, 8'h00);
      else expect_cycle("t6_beat", 1'b1, 2, 1'b1, 8'(8'h60 + c - 1));
      hs = bus.req_ready & bus.req_valid;
      if (c < 5) begin
        tick();
        advance(hs);
      end
    end
    #1 rst = 1'b0;
    #1 check_reset_outputs("t6_rst");
    lim[0] = 1; base[0] = 8'h20; last_at[0] = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    drive_frames(1'b0);
    @(negedge clk);
    expect_cycle("t6_arb", 1'b0, 0, 1'b0, 8'h00);
    tick(); drive_frames(1'b0); @(negedge clk);
    expect_cycle("t6_r0", 1'b1, 0, 1'b1, 8'h20);
    hs = bus.req_ready & bus.req_valid;
    tick(); advance(hs); drive_frames(1'b0); @(negedge clk);
    expect_cycle("t6_gap", 1'b0, 0, 1'b0, 8'h00);
    tick(); drive_frames(1'b0); @(negedge clk);
    expect_cycle("t6_r2", 1'b1, 2, 1'b1, 8'h64);

    // Randomized traffic against a transaction-level scoreboard.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < RLEN; k++) begin
        rb[i][k] = 8'($urandom);
        rl[i][k] = ($urandom_range(4) == 0);
      end
    prev_busy = 1'b0; prev_cause = 1'b0; prev_valid = '0; prev_owner = 0;
    last_owner = N - 1; beats = 0; idles = 0; cyc = 0; all_done = 1'b0;
    while (!all_done && cyc < 4000) begin
      v = '0; l = '0;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] < RLEN && $urandom_range(3) != 0) begin
          v[i] = 1'b1;
          d[i] = rb[i][cnt[i]];
          l[i] = rl[i][cnt[i]];
        end
      end
      full = ($urandom_range(4) == 0);
      drive(v, l, full);
      @(negedge clk);
      b = bus.busy;
      g = int'(bus.grant_id);
      if (!prev_busy) begin
        check("rnd_enter", 32'(b), 32'(|prev_valid));
        if (b) begin
          check("rnd_pick", 32'(g), 32'(rr(last_owner, prev_valid)));
          beats = 0;
          idles = 0;
        end
      end else begin
        check("rnd_release", 32'(!b), 32'(prev_cause));
        if (b) check("rnd_hold", 32'(g), 32'(prev_owner));
        else last_owner = prev_owner;
      end
      hs = '0;
      cause = 1'b0;
      if (b) begin
        exp_ready = full ? '0 : N'(1 << g);
        exp_wr = v[g] & ~full;
        check("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rnd_wr", 32'(bus.fifo_wr), 32'(exp_wr));
        if (exp_wr) begin
          check("rnd_data", 32'(bus.fifo_wdata), 32'(rb[g][cnt[g]]));
          hs[g] = 1'b1;
          beats++;
          idles = 0;
          cause = l[g] || (beats == MB);
        end else if (!v[g]) begin
          idles++;
          cause = (idles == TO);
        end
      end else begin
        check("rnd_idle_wr", 32'(bus.fifo_wr), 32'd0);
        check("rnd_idle_ready", 32'(bus.req_ready), 32'd0);
      end
      prev_busy = b; prev_owner = g; prev_cause = cause; prev_valid = v;
      tick();
      advance(hs);
      all_done = 1'b1;
      for (int i = 0; i < N; i++) if (cnt[i] < RLEN) all_done = 1'b0;
      cyc++;
    end
    for (int i = 0; i < N; i++) check("rnd_drain", 32'(cnt[i]), 32'(RLEN));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
